// File: rtl/axi_tb_pkg.sv
// Shared types for the AXI TB-side memory responder: response codes,
// write/read FSM state encodings and the new-data channel bit positions.
package axi_tb_pkg;

    typedef enum logic [1:0] {
        OKAY   = 2'b00,
        EXOKAY = 2'b01,
        SLVERR = 2'b10,
        DECERR = 2'b11
    } resp_t;

    typedef enum logic [1:0] {
        W_IDLE   = 2'b00,
        W_WAIT   = 2'b01,
        W_COMMIT = 2'b10,
        W_RESP   = 2'b11
    } wr_state_t;

    typedef enum logic [1:0] {
        R_IDLE  = 2'b00,
        R_FETCH = 2'b01,
        R_RESP  = 2'b10
    } rd_state_t;

    // Bit positions inside the 5-bit new-data / tx-enable vectors
    localparam int CH_AW = 4;
    localparam int CH_W  = 3;
    localparam int CH_B  = 2;
    localparam int CH_AR = 1;
    localparam int CH_R  = 0;

endpackage

// File: rtl/sub_mem_array.sv
// DEPTH x DATA_W storage with one write port and one registered read port.
// Contents are never reset; only the read output register is. A write and a
// read of the same word in one cycle returns the previous contents.
module sub_mem_array #(
    parameter int DATA_W = 64,
    parameter int DEPTH  = 256,
    parameter int IDX_W  = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [IDX_W-1:0]  wr_idx,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    input  logic              rd_zero,
    input  logic [IDX_W-1:0]  rd_idx,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem_r [DEPTH];
    logic [DATA_W-1:0] rd_data_r;

    // Store one word when the write port is enabled
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_r[wr_idx] <= wr_data;
        end
    end

    // Read output register: loads on rd_en (forced to zero for error responses), otherwise holds
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data_r <= {DATA_W{1'b0}};
        end else if (rd_en) begin
            rd_data_r <= rd_zero ? {DATA_W{1'b0}} : mem_r[rd_idx];
        end else begin
            rd_data_r <= rd_data_r;
        end
    end

    assign rd_data = rd_data_r;

endmodule

// File: rtl/axi_sub_mem_responder.sv
// Behavioural memory target behind the subordinate side of the TB interface.
// One outstanding write and one outstanding read, handled by independent FSMs.
// Optional feature macro: SUB_MEM_ERR_CHECK_EN enables DECERR for out-of-range
// addresses and SLVERR for misaligned ones (write suppressed, read data zero).
// Without it addresses wrap modulo DEPTH, low LSBs are ignored, responses are OKAY.
// DATA_W must be at least 16 so that the byte-offset field is non-empty.
module axi_sub_mem_responder #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 64,
    parameter int DEPTH  = 256
) (
    input  logic              ACLK,
    input  logic              ARESET,
    input  logic [ADDR_W-1:0] sub_rx_AW,
    input  logic [DATA_W-1:0] sub_rx_W,
    input  logic [ADDR_W-1:0] sub_rx_AR,
    input  logic [4:0]        sub_new_data,
    input  logic              b_ack,
    input  logic              r_ack,
    output logic [DATA_W-1:0] sub_tx_R,
    output logic [1:0]        sub_bresp,
    output logic [1:0]        sub_rresp,
    output logic              b_tx_en,
    output logic              r_tx_en,
    output logic              ovf
);

    import axi_tb_pkg::*;

    localparam int LSB   = $clog2(DATA_W / 8);
    localparam int IDX_W = $clog2(DEPTH);
    localparam logic [ADDR_W:0] MEM_BYTES = (ADDR_W + 1)'(DEPTH * (DATA_W / 8));
`ifdef SUB_MEM_ERR_CHECK_EN
    localparam bit ERR_CHECK = 1'b1;
`else
    localparam bit ERR_CHECK = 1'b0;
`endif

    // Response for an access at addr; always OKAY when checking is disabled
    function automatic resp_t addr_resp(input logic [ADDR_W-1:0] addr);
        resp_t resp;
        if (ERR_CHECK && ({1'b0, addr} >= MEM_BYTES)) begin
            resp = DECERR;
        end else if (ERR_CHECK && (addr[LSB-1:0] != {LSB{1'b0}})) begin
            resp = SLVERR;
        end else begin
            resp = OKAY;
        end
        return resp;
    endfunction

    // Channel pulses ([2] and [0] carry no meaning for this target)
    logic aw_pls_s, w_pls_s, ar_pls_s;
    logic unused_s;

    // Address/data latches
    logic              aw_vld_r, w_vld_r;
    logic [ADDR_W-1:0] aw_addr_r, ar_addr_r;
    logic [DATA_W-1:0] w_data_r;

    // FSM state
    wr_state_t wr_state_r, wr_next_s;
    rd_state_t rd_state_r, rd_next_s;

    // Decoded control
    logic  aw_take_s, w_take_s, ar_take_s, ovf_set_s;
    logic  b_done_s, r_done_s;
    resp_t wr_resp_s, rd_resp_s;
    logic  ram_wr_en_s, ram_rd_en_s, ram_rd_zero_s;
    logic  b_tx_en_d_s, r_tx_en_d_s;
    resp_t bresp_d_s, rresp_d_s;

    // Registered outputs
    logic  b_tx_en_r, r_tx_en_r, ovf_r;
    resp_t bresp_r, rresp_r;

    assign aw_pls_s = sub_new_data[CH_AW];
    assign w_pls_s  = sub_new_data[CH_W];
    assign ar_pls_s = sub_new_data[CH_AR];
    assign unused_s = sub_new_data[CH_B] ^ sub_new_data[CH_R];

    // A pulse is accepted only into an empty slot; otherwise it is dropped and flagged
    assign aw_take_s = aw_pls_s && !aw_vld_r;
    assign w_take_s  = w_pls_s && !w_vld_r;
    assign ar_take_s = ar_pls_s && (rd_state_r == R_IDLE);
    assign ovf_set_s = (aw_pls_s && aw_vld_r) || (w_pls_s && w_vld_r) ||
                       (ar_pls_s && (rd_state_r != R_IDLE));

    // Acks only count while the matching response is being offered
    assign b_done_s = b_ack && (wr_state_r == W_RESP);
    assign r_done_s = r_ack && (rd_state_r == R_RESP);

    assign wr_resp_s = addr_resp(aw_addr_r);
    assign rd_resp_s = addr_resp(ar_addr_r);

    // Capture AW/W/AR on accepted pulses; release them when the response completes
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            aw_vld_r  <= 1'b0;
            aw_addr_r <= {ADDR_W{1'b0}};
            w_vld_r   <= 1'b0;
            w_data_r  <= {DATA_W{1'b0}};
            ar_addr_r <= {ADDR_W{1'b0}};
        end else begin
            if (b_done_s) begin
                aw_vld_r  <= 1'b0;
                aw_addr_r <= {ADDR_W{1'b0}};
                w_vld_r   <= 1'b0;
                w_data_r  <= {DATA_W{1'b0}};
            end else begin
                if (aw_take_s) begin
                    aw_vld_r  <= 1'b1;
                    aw_addr_r <= sub_rx_AW;
                end
                if (w_take_s) begin
                    w_vld_r  <= 1'b1;
                    w_data_r <= sub_rx_W;
                end
            end
            if (r_done_s) begin
                ar_addr_r <= {ADDR_W{1'b0}};
            end else if (ar_take_s) begin
                ar_addr_r <= sub_rx_AR;
            end
        end
    end

    // State registers for the write and read FSMs
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            wr_state_r <= W_IDLE;
            rd_state_r <= R_IDLE;
        end else begin
            wr_state_r <= wr_next_s;
            rd_state_r <= rd_next_s;
        end
    end

    // Write FSM next state: commit once both halves are latched, then offer B until acked
    always_comb begin
        wr_next_s = wr_state_r;
        case (wr_state_r)
            W_IDLE: begin
                if (aw_vld_r && w_vld_r) begin
                    wr_next_s = W_COMMIT;
                end else if (aw_vld_r || w_vld_r) begin
                    wr_next_s = W_WAIT;
                end else begin
                    wr_next_s = W_IDLE;
                end
            end
            W_WAIT: begin
                if (aw_vld_r && w_vld_r) begin
                    wr_next_s = W_COMMIT;
                end else begin
                    wr_next_s = W_WAIT;
                end
            end
            W_COMMIT: wr_next_s = W_RESP;
            W_RESP: begin
                if (b_done_s) begin
                    wr_next_s = W_IDLE;
                end else begin
                    wr_next_s = W_RESP;
                end
            end
            default: wr_next_s = W_IDLE;
        endcase
    end

    // Write FSM outputs: single RAM write in W_COMMIT, next-cycle B enable and response
    always_comb begin
        ram_wr_en_s = (wr_state_r == W_COMMIT) && (wr_resp_s == OKAY);
        if (wr_next_s == W_RESP) begin
            b_tx_en_d_s = 1'b1;
            bresp_d_s   = wr_resp_s;
        end else begin
            b_tx_en_d_s = 1'b0;
            bresp_d_s   = OKAY;
        end
    end

    // Read FSM next state: accept AR when idle, one fetch cycle, then offer R until acked
    always_comb begin
        rd_next_s = rd_state_r;
        case (rd_state_r)
            R_IDLE: begin
                if (ar_take_s) begin
                    rd_next_s = R_FETCH;
                end else begin
                    rd_next_s = R_IDLE;
                end
            end
            R_FETCH: rd_next_s = R_RESP;
            R_RESP: begin
                if (r_done_s) begin
                    rd_next_s = R_IDLE;
                end else begin
                    rd_next_s = R_RESP;
                end
            end
            default: rd_next_s = R_IDLE;
        endcase
    end

    // Read FSM outputs: RAM read during R_FETCH, next-cycle R enable and response
    always_comb begin
        ram_rd_en_s   = (rd_state_r == R_FETCH);
        ram_rd_zero_s = (rd_resp_s != OKAY);
        if (rd_next_s == R_RESP) begin
            r_tx_en_d_s = 1'b1;
            rresp_d_s   = rd_resp_s;
        end else begin
            r_tx_en_d_s = 1'b0;
            rresp_d_s   = OKAY;
        end
    end

    // Output registers and the sticky overflow flag
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            b_tx_en_r <= 1'b0;
            bresp_r   <= OKAY;
            r_tx_en_r <= 1'b0;
            rresp_r   <= OKAY;
            ovf_r     <= 1'b0;
        end else begin
            b_tx_en_r <= b_tx_en_d_s;
            bresp_r   <= bresp_d_s;
            r_tx_en_r <= r_tx_en_d_s;
            rresp_r   <= rresp_d_s;
            ovf_r     <= ovf_r | ovf_set_s;
        end
    end

    sub_mem_array #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .IDX_W  (IDX_W)
    ) u_mem (
        .clk     (ACLK),
        .rst     (ARESET),
        .wr_en   (ram_wr_en_s),
        .wr_idx  (aw_addr_r[LSB +: IDX_W]),
        .wr_data (w_data_r),
        .rd_en   (ram_rd_en_s),
        .rd_zero (ram_rd_zero_s),
        .rd_idx  (ar_addr_r[LSB +: IDX_W]),
        .rd_data (sub_tx_R)
    );

    assign sub_bresp = bresp_r;
    assign sub_rresp = rresp_r;
    assign b_tx_en   = b_tx_en_r;
    assign r_tx_en   = r_tx_en_r;
    assign ovf       = ovf_r;

endmodule

// File: tb/tb_axi_sub_mem_responder.sv
// Directed self-checking bench for axi_sub_mem_responder.
// Inputs change 1 time unit after the rising edge; outputs are checked there too.
// Build with SUB_MEM_ERR_CHECK_EN defined to exercise the error-response variant.
module tb_axi_sub_mem_responder;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 64;
    localparam int DEPTH  = 256;
    localparam logic [31:0] OOR_ADDR = 32'(DEPTH * (DATA_W / 8));

    logic              ACLK;
    logic              ARESET;
    logic [ADDR_W-1:0] sub_rx_AW;
    logic [DATA_W-1:0] sub_rx_W;
    logic [ADDR_W-1:0] sub_rx_AR;
    logic [4:0]        sub_new_data;
    logic              b_ack;
    logic              r_ack;
    logic [DATA_W-1:0] sub_tx_R;
    logic [1:0]        sub_bresp;
    logic [1:0]        sub_rresp;
    logic              b_tx_en;
    logic              r_tx_en;
    logic              ovf;

    int errors = 0;
    int checks = 0;

    axi_sub_mem_responder #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) dut (
        .ACLK         (ACLK),
        .ARESET       (ARESET),
        .sub_rx_AW    (sub_rx_AW),
        .sub_rx_W     (sub_rx_W),
        .sub_rx_AR    (sub_rx_AR),
        .sub_new_data (sub_new_data),
        .b_ack        (b_ack),
        .r_ack        (r_ack),
        .sub_tx_R     (sub_tx_R),
        .sub_bresp    (sub_bresp),
        .sub_rresp    (sub_rresp),
        .b_tx_en      (b_tx_en),
        .r_tx_en      (r_tx_en),
        .ovf          (ovf)
    );

    initial ACLK = 1'b0;
    always #5 ACLK = ~ACLK;

    // Global time bound
    initial begin
        #200000;
        $display("FAIL watchdog: run exceeded its time limit");
        $fatal(1);
    end

    task automatic tick();
        @(posedge ACLK);
        #1;
    endtask

    task automatic pulse(input logic [4:0] ch);
        sub_new_data = ch;
        tick();
        sub_new_data = 5'b00000;
    endtask

    task automatic ack_b();
        b_ack = 1'b1;
        tick();
        b_ack = 1'b0;
    endtask

    task automatic ack_r();
        r_ack = 1'b1;
        tick();
        r_ack = 1'b0;
    endtask

    // Full write that ends back in idle
    task automatic write_word(input logic [31:0] addr, input logic [63:0] data);
        sub_rx_AW = addr;
        sub_rx_W  = data;
        pulse(5'b11000);
        tick();
        tick();
        ack_b();
    endtask

    // Issues a read and returns with the response being offered
    task automatic read_word(input logic [31:0] addr);
        sub_rx_AR = addr;
        pulse(5'b00010);
        tick();
    endtask

    task automatic test_reset();
        ARESET = 1'b1;
        tick();
        tick();
        checks++; if (sub_tx_R !== 64'h0) begin errors++; $display("FAIL reset_R got=%h exp=0", sub_tx_R); end
        checks++; if (sub_bresp !== 2'b00) begin errors++; $display("FAIL reset_bresp got=%b exp=00", sub_bresp); end
        checks++; if (sub_rresp !== 2'b00) begin errors++; $display("FAIL reset_rresp got=%b exp=00", sub_rresp); end
        checks++; if (b_tx_en !== 1'b0) begin errors++; $display("FAIL reset_b_tx_en got=%b exp=0", b_tx_en); end
        checks++; if (r_tx_en !== 1'b0) begin errors++; $display("FAIL reset_r_tx_en got=%b exp=0", r_tx_en); end
        checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL reset_ovf got=%b exp=0", ovf); end
        ARESET = 1'b0;
        tick();
    endtask

    task automatic test_write_read();
        sub_rx_AW = 32'h10;
        sub_rx_W  = 64'h0000_0000_DEAD_BEEF;
        pulse(5'b11000);
        tick();
        checks++; if (b_tx_en !== 1'b0) begin errors++; $display("FAIL wr_lat_t2 got=%b exp=0", b_tx_en); end
        tick();
        checks++; if (b_tx_en !== 1'b1) begin errors++; $display("FAIL wr_lat_t3 got=%b exp=1", b_tx_en); end
        checks++; if (sub_bresp !== 2'b00) begin errors++; $display("FAIL wr_bresp got=%b exp=00", sub_bresp); end
        ack_b();
        checks++; if (b_tx_en !== 1'b0) begin errors++; $display("FAIL wr_b_drop got=%b exp=0", b_tx_en); end
        sub_rx_AR = 32'h10;
        pulse(5'b00010);
        checks++; if (r_tx_en !== 1'b0) begin errors++; $display("FAIL rd_lat_t1 got=%b exp=0", r_tx_en); end
        tick();
        checks++; if (r_tx_en !== 1'b1) begin errors++; $display("FAIL rd_lat_t2 got=%b exp=1", r_tx_en); end
        checks++; if (sub_tx_R !== 64'h0000_0000_DEAD_BEEF) begin errors++; $display("FAIL rd_data got=%h exp=deadbeef", sub_tx_R); end
        checks++; if (sub_rresp !== 2'b00) begin errors++; $display("FAIL rd_rresp got=%b exp=00", sub_rresp); end
        ack_r();
        checks++; if (r_tx_en !== 1'b0) begin errors++; $display("FAIL rd_r_drop got=%b exp=0", r_tx_en); end
    endtask

    task automatic test_split();
        sub_rx_W = 64'h1122_3344_5566_7788;
        pulse(5'b01000);
        tick();
        tick();
        tick();
        checks++; if (b_tx_en !== 1'b0) begin errors++; $display("FAIL split_wait got=%b exp=0", b_tx_en); end
        sub_rx_AW = 32'h40;
        pulse(5'b10000);
        tick();
        checks++; if (b_tx_en !== 1'b0) begin errors++; $display("FAIL split_t6 got=%b exp=0", b_tx_en); end
        tick();
        checks++; if (b_tx_en !== 1'b1) begin errors++; $display("FAIL split_t7 got=%b exp=1", b_tx_en); end
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++; if (b_tx_en !== 1'b1 || sub_bresp !== 2'b00) begin
                errors++; $display("FAIL split_hold%0d b_tx_en=%b bresp=%b exp 1/00", i, b_tx_en, sub_bresp);
            end
        end
        ack_b();
        checks++; if (b_tx_en !== 1'b0) begin errors++; $display("FAIL split_drop got=%b exp=0", b_tx_en); end
        read_word(32'h40);
        checks++; if (sub_tx_R !== 64'h1122_3344_5566_7788) begin errors++; $display("FAIL split_data got=%h exp=1122334455667788", sub_tx_R); end
        ack_r();
    endtask

    task automatic test_collision();
        write_word(32'h88, 64'h5A);
        checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL coll_pre_ovf got=%b exp=0", ovf); end
        sub_rx_AW = 32'h80;
        sub_rx_W  = 64'hA5;
        pulse(5'b11000);
        tick();
        tick();
        sub_rx_AW = 32'h88;
        pulse(5'b10000);
        checks++; if (ovf !== 1'b1) begin errors++; $display("FAIL coll_ovf got=%b exp=1", ovf); end
        checks++; if (b_tx_en !== 1'b1) begin errors++; $display("FAIL coll_b_held got=%b exp=1", b_tx_en); end
        ack_b();
        tick();
        tick();
        tick();
        tick();
        checks++; if (b_tx_en !== 1'b0) begin errors++; $display("FAIL coll_no_second got=%b exp=0", b_tx_en); end
        checks++; if (ovf !== 1'b1) begin errors++; $display("FAIL coll_ovf_sticky got=%b exp=1", ovf); end
        read_word(32'h80);
        checks++; if (sub_tx_R !== 64'hA5) begin errors++; $display("FAIL coll_first got=%h exp=a5", sub_tx_R); end
        ack_r();
        read_word(32'h88);
        checks++; if (sub_tx_R !== 64'h5A) begin errors++; $display("FAIL coll_untouched got=%h exp=5a", sub_tx_R); end
        ack_r();
    endtask

    task automatic test_read_before_write();
        write_word(32'h20, 64'h1);
        sub_rx_AW = 32'h20;
        sub_rx_W  = 64'h2;
        pulse(5'b11000);
        sub_rx_AR = 32'h20;
        pulse(5'b00010);
        tick();
        checks++; if (r_tx_en !== 1'b1 || b_tx_en !== 1'b1) begin
            errors++; $display("FAIL rbw_enables r=%b b=%b exp 1/1", r_tx_en, b_tx_en);
        end
        checks++; if (sub_tx_R !== 64'h1) begin errors++; $display("FAIL rbw_old got=%h exp=1", sub_tx_R); end
        b_ack = 1'b1;
        r_ack = 1'b1;
        tick();
        b_ack = 1'b0;
        r_ack = 1'b0;
        read_word(32'h20);
        checks++; if (sub_tx_R !== 64'h2) begin errors++; $display("FAIL rbw_new got=%h exp=2", sub_tx_R); end
        ack_r();
    endtask

    task automatic test_err_check();
        write_word(32'h0, 64'h77);
`ifdef SUB_MEM_ERR_CHECK_EN
        read_word(OOR_ADDR);
        checks++; if (sub_rresp !== 2'b11) begin errors++; $display("FAIL err_rd_decerr got=%b exp=11", sub_rresp); end
        checks++; if (sub_tx_R !== 64'h0) begin errors++; $display("FAIL err_rd_zero got=%h exp=0", sub_tx_R); end
        ack_r();
        read_word(32'h5);
        checks++; if (sub_rresp !== 2'b10 || sub_tx_R !== 64'h0) begin
            errors++; $display("FAIL err_rd_slverr rresp=%b R=%h exp 10/0", sub_rresp, sub_tx_R);
        end
        ack_r();
        sub_rx_AW = 32'h3;
        sub_rx_W  = 64'hFFFF;
        pulse(5'b11000);
        tick();
        tick();
        checks++; if (sub_bresp !== 2'b10) begin errors++; $display("FAIL err_wr_slverr got=%b exp=10", sub_bresp); end
        ack_b();
        read_word(32'h0);
        checks++; if (sub_tx_R !== 64'h77) begin errors++; $display("FAIL err_wr_suppressed got=%h exp=77", sub_tx_R); end
        ack_r();
`else
        sub_rx_AW = OOR_ADDR;
        sub_rx_W  = 64'h99;
        pulse(5'b11000);
        tick();
        tick();
        checks++; if (sub_bresp !== 2'b00) begin errors++; $display("FAIL wrap_bresp got=%b exp=00", sub_bresp); end
        ack_b();
        read_word(32'h0);
        checks++; if (sub_tx_R !== 64'h99) begin errors++; $display("FAIL wrap_word0 got=%h exp=99", sub_tx_R); end
        ack_r();
        read_word(32'h5);
        checks++; if (sub_tx_R !== 64'h99 || sub_rresp !== 2'b00) begin
            errors++; $display("FAIL wrap_lsb R=%h rresp=%b exp 99/00", sub_tx_R, sub_rresp);
        end
        ack_r();
`endif
    endtask

    task automatic test_reset_mid();
        read_word(32'h20);
        checks++; if (r_tx_en !== 1'b1) begin errors++; $display("FAIL mid_r_resp got=%b exp=1", r_tx_en); end
        sub_rx_W = 64'hBAD;
        pulse(5'b01000);
        tick();
        ARESET = 1'b1;
        tick();
        checks++; if (sub_tx_R !== 64'h0) begin errors++; $display("FAIL mid_R got=%h exp=0", sub_tx_R); end
        checks++; if (r_tx_en !== 1'b0 || b_tx_en !== 1'b0) begin
            errors++; $display("FAIL mid_enables r=%b b=%b exp 0/0", r_tx_en, b_tx_en);
        end
        checks++; if (sub_bresp !== 2'b00 || sub_rresp !== 2'b00) begin
            errors++; $display("FAIL mid_resp b=%b r=%b exp 00/00", sub_bresp, sub_rresp);
        end
        checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL mid_ovf got=%b exp=0", ovf); end
        ARESET = 1'b0;
        tick();
        sub_rx_AW = 32'h20;
        pulse(5'b10000);
        tick();
        tick();
        tick();
        checks++; if (b_tx_en !== 1'b0) begin errors++; $display("FAIL mid_w_abandoned got=%b exp=0", b_tx_en); end
        read_word(32'h20);
        checks++; if (sub_tx_R !== 64'h2) begin errors++; $display("FAIL mid_ram_kept got=%h exp=2", sub_tx_R); end
        ack_r();
    endtask

    initial begin
        ARESET       = 1'b1;
        sub_rx_AW    = 32'h0;
        sub_rx_W     = 64'h0;
        sub_rx_AR    = 32'h0;
        sub_new_data = 5'b00000;
        b_ack        = 1'b0;
        r_ack        = 1'b0;
        tick();
        test_reset();
        test_write_read();
        test_split();
        test_collision();
        test_read_before_write();
        test_err_check();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
